// File: rtl/link_uart_rx.sv
// 8N1 UART receiver: 2-FF input synchronizer, start-centre qualification,
// centre sampling of data/stop bits, framing-error pulse and break handling.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | line idle, waiting for rxd_s low
// START     | timing to start-bit centre, glitch rejected if high there
// DATA      | sampling 8 data bits at bit centres, LSB first
// STOP      | sampling stop bit; high -> byte out, low -> frame_err
// WAIT_HIGH | line held low after framing error, wait for release
module link_uart_rx #(
  parameter int BIT_DIV  = 217,
  parameter int HALF_DIV = BIT_DIV / 2
) (
  input  logic       clk_25,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_byte_rsvd,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int TW = $clog2(BIT_DIV);
  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    index_q, index_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q,  byte_d;
  logic          rsvd_q,  rsvd_d;
  logic          ferr_q,  ferr_d;
  logic          rxd_m, rxd_s;

  always_ff @(posedge clk_25) begin
    if (rst) begin
      rxd_m   <= 1'b1;
      rxd_s   <= 1'b1;
      state_q <= IDLE;
      timer_q <= '0;
      index_q <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      rsvd_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rxd_m   <= rxd;
      rxd_s   <= rxd_m;
      state_q <= state_d;
      timer_q <= timer_d;
      index_q <= index_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      rsvd_q  <= rsvd_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    index_d = index_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    rsvd_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!rxd_s) state_d = START;
      end
      START: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          index_d = '0;
          state_d = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d          = '0;
          shift_d[index_q] = rxd_s;
          index_d          = index_q + 3'd1;
          if (index_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (rxd_s) begin
            byte_d  = shift_q;
            rsvd_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // Timer is parked so a long break cannot run it past a bit period.
        timer_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign rx_byte      = byte_q;
  assign rx_byte_rsvd = rsvd_q;
  assign frame_err    = ferr_q;
  assign rx_busy      = (state_q != IDLE);

endmodule
